// File: rtl/sseg_scan_display_pkg.sv
// ---------------------------------------------------------------------------
// sseg_pkg : shared constants for the multiplexed 7-segment display slice.
//   SEG_0..SEG_F : active-low {g,f,e,d,c,b,a} codes for the hex digits
//   SEG_BLANK    : all segments dark
//   AN_OFF       : level that switches a digit enable off (anodes active-low)
//   hex_to_seg() : nibble -> 7-bit active-low segment pattern
// ---------------------------------------------------------------------------
package sseg_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic       AN_OFF    = 1'b1;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
      logic [6:0] seg;
      case (nibble)
         4'h0:    seg = SEG_0;
         4'h1:    seg = SEG_1;
         4'h2:    seg = SEG_2;
         4'h3:    seg = SEG_3;
         4'h4:    seg = SEG_4;
         4'h5:    seg = SEG_5;
         4'h6:    seg = SEG_6;
         4'h7:    seg = SEG_7;
         4'h8:    seg = SEG_8;
         4'h9:    seg = SEG_9;
         4'hA:    seg = SEG_A;
         4'hB:    seg = SEG_B;
         4'hC:    seg = SEG_C;
         4'hD:    seg = SEG_D;
         4'hE:    seg = SEG_E;
         default: seg = SEG_F;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/sseg_scan_display_if.sv
// ---------------------------------------------------------------------------
// sseg_scan_display_if : display data in / pin drive out bundle.
//   value      : packed hex nibbles, digit i = value[4i+3:4i]
//   dp         : decimal point request per digit, 1 = lit
//   enable     : 1 = display on, 0 = all dark
//   an         : active-low digit enables
//   sseg       : active-low segments {dp,g,f,e,d,c,b,a}
//   frame_done : one-cycle pulse at each frame start
// master = data source, slave = display driver.
// ---------------------------------------------------------------------------
interface sseg_scan_display_if #(
   parameter int unsigned DIGITS = 4
);
   logic [4*DIGITS-1:0] value;
   logic [DIGITS-1:0]   dp;
   logic                enable;
   logic [DIGITS-1:0]   an;
   logic [7:0]          sseg;
   logic                frame_done;

   modport master (
      output value, dp, enable,
      input  an, sseg, frame_done
   );

   modport slave (
      input  value, dp, enable,
      output an, sseg, frame_done
   );
endinterface

// File: rtl/sseg_scan_display_hex_decoder.sv
// ---------------------------------------------------------------------------
// sseg_hex_decoder : combinational hex nibble -> 7-segment decoder.
//   i_nibble : hex digit 0..F
//   o_seg    : active-low {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module sseg_hex_decoder
   import sseg_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = hex_to_seg(i_nibble);
   end

endmodule

// File: rtl/sseg_scan_display.sv
// ---------------------------------------------------------------------------
// sseg_scan_display : time-multiplexed DIGITS-wide 7-segment driver.
//   clk  : system clock, rising edge
//   rst  : synchronous active-low reset
//   bus  : sseg_scan_display_if.slave (value/dp/enable in, an/sseg/frame_done out)
// Each digit is lit for PRESCALE cycles in order 0..DIGITS-1. value/dp are
// captured into a shadow once per frame so a changing count never tears.
// Optional: define SSEG_SCAN_LEADING_ZERO_BLANK_EN to blank leading zeros.
// ---------------------------------------------------------------------------
module sseg_scan_display
   import sseg_pkg::*;
#(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned PRESCALE = 4
)(
   input  logic                clk,
   input  logic                rst,
   sseg_scan_display_if.slave  bus
);

   localparam int unsigned IW = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;
   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PW-1:0]       r_presc;
   logic [IW-1:0]       r_idx;
   logic [4*DIGITS-1:0] r_shadow_val;
   logic [DIGITS-1:0]   r_shadow_dp;
   logic [DIGITS-1:0]   r_an;
   logic [7:0]          r_sseg;
   logic                r_frame_done;

   logic                w_tick;
   logic                w_last;
   logic [3:0]          w_nib;
   logic                w_dp;
   logic [DIGITS-1:0]   w_an;
   logic [6:0]          w_dec;
   logic [6:0]          w_seg;

   assign w_tick = (r_presc == PW'(PRESCALE - 1));
   assign w_last = (r_idx == IW'(DIGITS - 1));

   // Select the current digit's nibble, dp and anode pattern from the shadow.
   always_comb begin
      w_nib = '0;
      w_dp  = 1'b0;
      w_an  = '1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (r_idx == IW'(i)) begin
            w_nib = r_shadow_val[4*i +: 4];
            w_dp  = r_shadow_dp[i];
            w_an[i] = ~AN_OFF;
         end
      end
   end

   sseg_hex_decoder u_dec (
      .i_nibble (w_nib),
      .o_seg    (w_dec)
   );

`ifdef SSEG_SCAN_LEADING_ZERO_BLANK_EN
   logic [IW-1:0] w_msd;

   // Highest nonzero shadow digit; stays 0 for an all-zero value so digit 0
   // is never blanked.
   always_comb begin
      w_msd = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (r_shadow_val[4*i +: 4] != 4'h0) begin
            w_msd = IW'(i);
         end
      end
   end

   assign w_seg = (r_idx > w_msd) ? SEG_BLANK : w_dec;
`else
   assign w_seg = w_dec;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_presc      <= '0;
         r_idx        <= '0;
         r_shadow_val <= '0;
         r_shadow_dp  <= '0;
         r_an         <= '1;
         r_sseg       <= '1;
         r_frame_done <= 1'b0;
      end else begin
         r_presc      <= w_tick ? '0 : r_presc + 1'b1;
         r_frame_done <= w_tick && w_last;
         if (w_tick) begin
            r_idx <= w_last ? '0 : r_idx + 1'b1;
            if (w_last) begin
               r_shadow_val <= bus.value;
               r_shadow_dp  <= bus.dp;
            end
         end
         if (bus.enable) begin
            r_an   <= w_an;
            r_sseg <= {~w_dp, w_seg};
         end else begin
            r_an   <= '1;
            r_sseg <= '1;
         end
      end
   end

   assign bus.an         = r_an;
   assign bus.sseg       = r_sseg;
   assign bus.frame_done = r_frame_done;

endmodule
